// File: rtl/cache_prof_pkg.sv
// Shared types and width helpers for the cache hit profiler.
package cache_prof_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_UPDATE = 2'd2
    } state_e;

    function automatic int off_bits(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int idx_bits(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_bits(input int addr_w, input int line_bytes, input int sets);
        return addr_w - $clog2(line_bytes) - $clog2(sets);
    endfunction

    // Way index and LRU age share this width; a direct-mapped cache keeps one constant bit.
    function automatic int age_bits(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max_v;
        max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= max_v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/cache_lru_set.sv
// One set: parallel tag compare, victim choice (first invalid, else oldest) and true-LRU age update.
// Purely combinational; the caller registers results.
module cache_lru_set
    import cache_prof_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int TAG_W = 22,
    parameter int W_W   = age_bits(WAYS)
) (
    input  logic [WAYS-1:0]            valid,
    input  logic [WAYS-1:0][TAG_W-1:0] tags,
    input  logic [WAYS-1:0][W_W-1:0]   ages,
    input  logic [TAG_W-1:0]           lookup_tag,
    input  logic [W_W-1:0]             touch_way,
    output logic                       hit,
    output logic [W_W-1:0]             hit_way,
    output logic [W_W-1:0]             victim_way,
    output logic [WAYS-1:0][W_W-1:0]   ages_next
);

    logic           found_inv;
    logic [W_W-1:0] inv_way;
    logic [W_W-1:0] lru_way;
    logic [W_W-1:0] touch_age;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        found_inv = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid[w] && (tags[w] == lookup_tag) && !hit) begin
                hit     = 1'b1;
                hit_way = W_W'(w);
            end
            if (!valid[w] && !found_inv) begin
                found_inv = 1'b1;
                inv_way   = W_W'(w);
            end
            if (ages[w] == W_W'(WAYS - 1)) begin
                lru_way = W_W'(w);
            end
        end
        victim_way = found_inv ? inv_way : lru_way;
    end

    // The touched way becomes MRU; only younger ways age, so ages stay a permutation.
    always_comb begin
        touch_age = ages[touch_way];
        ages_next = ages;
        for (int w = 0; w < WAYS; w++) begin
            if (W_W'(w) == touch_way) begin
                ages_next[w] = '0;
            end else if (ages[w] < touch_age) begin
                ages_next[w] = ages[w] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_hit_profiler.sv
// Set-associative true-LRU cache model counting saturating hits, misses and accesses.
// Accept -> LOOKUP -> UPDATE, results visible 3 cycles after accept; trace_ready low while busy.
module cache_hit_profiler
    import cache_prof_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 64,
    parameter int WAYS       = 4,
    parameter int CNT_W      = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              trace_valid,
    output logic              trace_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic              clear,
    output logic              updated,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
    output logic [CNT_W-1:0]  access_count
);

    localparam int OFF_W  = off_bits(LINE_BYTES);
    localparam int IDX_W  = idx_bits(SETS);
    localparam int TAG_W  = tag_bits(ADDR_W, LINE_BYTES, SETS);
    localparam int W_W    = age_bits(WAYS);
    localparam int LINE_W = ADDR_W - OFF_W;

    state_e                                state_q, state_d;
    logic [LINE_W-1:0]                     line_q, line_d;
    logic                                  hit_q, hit_d;
    logic [W_W-1:0]                        hit_way_q, hit_way_d;
    logic [W_W-1:0]                        victim_q, victim_d;
    logic                                  ready_q, ready_d;
    logic                                  upd_q, upd_d;
    logic [CNT_W-1:0]                      hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]                      miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0]                      acc_cnt_q, acc_cnt_d;
    logic [SETS-1:0][WAYS-1:0]             valid_q, valid_d;
    logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]  tag_q, tag_d;
    logic [SETS-1:0][WAYS-1:0][W_W-1:0]    age_q, age_d;

    logic [IDX_W-1:0]          set_idx;
    logic [TAG_W-1:0]          line_tag;
    logic                      set_hit;
    logic [W_W-1:0]            set_hit_way;
    logic [W_W-1:0]            set_victim;
    logic [WAYS-1:0][W_W-1:0]  set_ages_next;
    logic                      unused_offset;

    // Only the line address is kept; byte-offset bits never affect the result.
    assign unused_offset = ^mem_addr[OFF_W-1:0];
    assign set_idx       = line_q[IDX_W-1:0];
    assign line_tag      = line_q[LINE_W-1 -: TAG_W];

    cache_lru_set #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W),
        .W_W   (W_W)
    ) u_set (
        .valid      (valid_q[set_idx]),
        .tags       (tag_q[set_idx]),
        .ages       (age_q[set_idx]),
        .lookup_tag (line_tag),
        .touch_way  (hit_q ? hit_way_q : victim_q),
        .hit        (set_hit),
        .hit_way    (set_hit_way),
        .victim_way (set_victim),
        .ages_next  (set_ages_next)
    );

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        hit_d      = hit_q;
        hit_way_d  = hit_way_q;
        victim_d   = victim_q;
        upd_d      = 1'b0;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        acc_cnt_d  = acc_cnt_q;
        valid_d    = valid_q;
        tag_d      = tag_q;
        age_d      = age_q;

        case (state_q)
            ST_IDLE: begin
                if (trace_valid && ready_q) begin
                    line_d  = mem_addr[ADDR_W-1:OFF_W];
                    state_d = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                hit_d     = set_hit;
                hit_way_d = set_hit_way;
                victim_d  = set_victim;
                state_d   = ST_UPDATE;
            end
            ST_UPDATE: begin
                age_d[set_idx] = set_ages_next;
                if (!hit_q) begin
                    valid_d[set_idx][victim_q] = 1'b1;
                    tag_d[set_idx][victim_q]   = line_tag;
                end
                acc_cnt_d = CNT_W'(sat_inc(32'(acc_cnt_q), CNT_W));
                if (hit_q) begin
                    hit_cnt_d = CNT_W'(sat_inc(32'(hit_cnt_q), CNT_W));
                end else begin
                    miss_cnt_d = CNT_W'(sat_inc(32'(miss_cnt_q), CNT_W));
                end
                upd_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (clear) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
            acc_cnt_d  = '0;
        end

        ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            line_q     <= '0;
            hit_q      <= 1'b0;
            hit_way_q  <= '0;
            victim_q   <= '0;
            ready_q    <= 1'b0;
            upd_q      <= 1'b0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            acc_cnt_q  <= '0;
            valid_q    <= '0;
            tag_q      <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    age_q[s][w] <= W_W'(w);
                end
            end
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            hit_q      <= hit_d;
            hit_way_q  <= hit_way_d;
            victim_q   <= victim_d;
            ready_q    <= ready_d;
            upd_q      <= upd_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            acc_cnt_q  <= acc_cnt_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            age_q      <= age_d;
        end
    end

    assign trace_ready  = ready_q;
    assign updated      = upd_q;
    assign hit_count    = hit_cnt_q;
    assign miss_count   = miss_cnt_q;
    assign access_count = acc_cnt_q;

endmodule
